// File: rtl/multicycle_alu.sv
// Purpose: execute-stage ALU; ADD/SUB/OR/LUI in one step, SLL/SRL one bit per cycle.
// Latency: done_o one cycle after start for single-step ops and shamt 0, shamt+1 cycles for shifts.
// Backpressure: start_i is ignored while busy_o is high; requests are never queued.
module multicycle_alu #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [3:0]            ALU_Operation_i,
    input  logic [DATA_WIDTH-1:0] A_i,
    input  logic [DATA_WIDTH-1:0] B_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] ALU_Result_o,
    output logic                  Zero_o
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_SLL = 4'b0010;
    localparam logic [3:0] OP_SRL = 4'b0011;
    localparam logic [3:0] OP_LUI = 4'b1000;
    localparam logic [3:0] OP_OR  = 4'b1001;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    // Only the shift direction is needed after capture; single-step ops finish
    // in the capture cycle, so the full op code is not kept.
    logic                    shift_right_q, shift_right_d;
    logic [DATA_WIDTH-1:0]   work_q, work_d;
    logic [SHAMT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic                    zero_q, zero_d;

    logic [SHAMT_WIDTH-1:0]  shamt_in;
    logic                    is_shift_in;
    logic [DATA_WIDTH-1:0]   single_result;
    logic [DATA_WIDTH-1:0]   shift_one;

    assign shamt_in    = B_i[SHAMT_WIDTH-1:0];
    assign is_shift_in = (ALU_Operation_i == OP_SLL) || (ALU_Operation_i == OP_SRL);

    // Result of every op that completes without iterating (shifts by 0 return A).
    always_comb begin
        single_result = '0;
        case (ALU_Operation_i)
            OP_ADD:  single_result = A_i + B_i;
            OP_SUB:  single_result = A_i - B_i;
            OP_OR:   single_result = A_i | B_i;
            OP_LUI:  single_result = B_i;
            OP_SLL:  single_result = A_i;
            OP_SRL:  single_result = A_i;
            default: single_result = '0;
        endcase
    end

    // One-bit step of the working register in the captured direction.
    always_comb begin
        shift_one = shift_right_q ? (work_q >> 1) : (work_q << 1);
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: shifts with non-zero amount iterate, everything else finishes at once.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (is_shift_in && (shamt_in != '0)) begin
                        state_d = S_SHIFT;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                if (cnt_q == SHAMT_WIDTH'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        busy_o = (state_q != S_IDLE);
        done_o = (state_q == S_DONE);
    end

    // Datapath next values: capture in IDLE, iterate in SHIFT, result loaded on entry to DONE.
    always_comb begin
        shift_right_d = shift_right_q;
        work_d        = work_q;
        cnt_d         = cnt_q;
        result_d      = result_q;
        zero_d        = zero_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    shift_right_d = (ALU_Operation_i == OP_SRL);
                    work_d        = A_i;
                    cnt_d         = is_shift_in ? shamt_in : '0;
                    if (!(is_shift_in && (shamt_in != '0))) begin
                        result_d = single_result;
                        zero_d   = (single_result == '0);
                    end
                end
            end
            S_SHIFT: begin
                work_d = shift_one;
                cnt_d  = cnt_q - SHAMT_WIDTH'(1);
                if (cnt_q == SHAMT_WIDTH'(1)) begin
                    result_d = shift_one;
                    zero_d   = (shift_one == '0);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; a reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_right_q <= 1'b0;
            work_q        <= '0;
            cnt_q         <= '0;
            result_q      <= '0;
            zero_q        <= 1'b1;
        end else begin
            shift_right_q <= shift_right_d;
            work_q        <= work_d;
            cnt_q         <= cnt_d;
            result_q      <= result_d;
            zero_q        <= zero_d;
        end
    end

    assign ALU_Result_o = result_q;
    assign Zero_o       = zero_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Purpose: randomized and directed stimulus for multicycle_alu with a queue-based scoreboard.
// Latency: expected done cycle is recorded per request and checked by the monitor.
// Backpressure: requests are issued only when busy_o is low; extra start pulses test the ignore path.
module tb_multicycle_alu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0;
    logic [3:0]  alu_op = 4'b0000;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        busy_o;
    logic        done_o;
    logic [31:0] alu_result;
    logic        zero_o;

    multicycle_alu #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start_i),
        .ALU_Operation_i (alu_op),
        .A_i             (a_in),
        .B_i             (b_in),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .ALU_Result_o    (alu_result),
        .Zero_o          (zero_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] res;
        int          at;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_res = '0;
    bit          prev_done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain arithmetic on the op code rules.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b1001: return a | b;
            4'b1000: return b;
            4'b0010: return a << b[4:0];
            4'b0011: return a >> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_extra_cycles(input logic [3:0] op, input logic [31:0] b);
        if (op == 4'b0010 || op == 4'b0011) return int'(b[4:0]);
        return 0;
    endfunction

    // Monitor: reset values, scoreboard pops on done_o, hold checks otherwise.
    always @(negedge clk) begin
        if (!reset) begin
            sb_q.delete();
            last_res  = '0;
            prev_done = 1'b0;
            check("reset_busy", 64'(busy_o), 64'd0);
            check("reset_done", 64'(done_o), 64'd0);
            check("reset_result", 64'(alu_result), 64'd0);
            check("reset_zero", 64'(zero_o), 64'd1);
        end else if (done_o) begin
            check("done_back_to_back", 64'(prev_done), 64'd0);
            if (sb_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result", 64'(alu_result), 64'(e.res));
                check("zero", 64'(zero_o), 64'(e.res == 32'd0));
                check("done_cycle", 64'(cyc), 64'(e.at));
                last_res = e.res;
            end
            prev_done = 1'b1;
        end else begin
            check("hold_result", 64'(alu_result), 64'(last_res));
            check("hold_zero", 64'(zero_o), 64'(last_res == 32'd0));
            prev_done = 1'b0;
        end
    end

    // Wait (bounded) until the DUT is idle; called at posedge+1.
    task automatic wait_idle();
        int guard = 0;
        while (busy_o && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (busy_o) begin
            check("idle_timeout", 64'd1, 64'd0);
        end
    endtask

    // Issue one request; optionally pulse start_i with new operands while busy.
    task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv, input bit poke);
        exp_t e;
        wait_idle();
        alu_op  = op;
        a_in    = av;
        b_in    = bv;
        start_i = 1'b1;
        e.res   = ref_alu(op, av, bv);
        e.at    = cyc + 1 + ref_extra_cycles(op, bv);
        sb_q.push_back(e);
        @(posedge clk); #1;
        start_i = 1'b0;
        alu_op  = 4'($urandom);
        a_in    = $urandom;
        b_in    = $urandom;
        if (poke) begin
            start_i = 1'b1;
            @(posedge clk); #1;
            start_i = 1'b0;
            a_in    = $urandom;
            b_in    = $urandom;
        end
    endtask

    logic [3:0] op_tbl [8];

    initial begin
        op_tbl = '{4'b0000, 4'b0001, 4'b1001, 4'b1000, 4'b0010, 4'b0011, 4'b1111, 4'b0101};

        // Reset held low for three cycles.
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        // Arithmetic.
        issue(4'b0000, 32'd7, 32'd5, 1'b0);
        issue(4'b0001, 32'd5, 32'd5, 1'b0);
        issue(4'b0001, 32'd0, 32'd1, 1'b0);
        // Shifts, including shamt 0 from B=32.
        issue(4'b0010, 32'd1, 32'd31, 1'b0);
        issue(4'b0011, 32'h8000_0000, 32'd4, 1'b0);
        issue(4'b0010, 32'hDEAD_BEEF, 32'd32, 1'b0);
        // Logic, LUI, undefined op.
        issue(4'b1001, 32'h0000_00F0, 32'h0000_000F, 1'b0);
        issue(4'b1000, 32'hFFFF_FFFF, 32'h1234_5000, 1'b0);
        issue(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        // Start pulse during SHIFT is ignored; next start is right after done.
        issue(4'b0011, 32'hF000_0000, 32'd8, 1'b1);
        issue(4'b0000, 32'hFFFF_FFFF, 32'd1, 1'b0);

        // Reset mid-shift: aborts with no done_o.
        issue(4'b0010, 32'h0000_0003, 32'd10, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("abort_busy", 64'(busy_o), 64'd0);
        check("abort_result", 64'(alu_result), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        issue(4'b0000, 32'd100, 32'd23, 1'b0);

        // Randomized mix.
        for (int i = 0; i < 60; i++) begin
            logic [3:0]  op;
            logic [31:0] av;
            logic [31:0] bv;
            op = op_tbl[$urandom_range(0, 7)];
            av = $urandom;
            bv = $urandom;
            if ($urandom_range(0, 3) == 0) av = bv;
            issue(op, av, bv, ($urandom_range(0, 3) == 0));
        end

        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
